// File: rtl/onewire_slot_decoder.sv
// 1-Wire slot timer/classifier for the virtual DS2431 slave.
// Decodes write/read slots and answers reset pulses with presence.
module onewire_slot_decoder #(
  parameter int CNT_W       = 13,
  parameter int T_MIN_LOW   = 5,
  parameter int T_SAMPLE    = 300,
  parameter int T_READ_HOLD = 300,
  parameter int T_RESET_MIN = 4000,
  parameter int T_PD_WAIT   = 300,
  parameter int T_PD_LOW    = 1200
) (
  input  logic clk,
  input  logic nRst,
  input  logic fall,
  input  logic dq_in,
  input  logic tx_en,
  input  logic tx_bit,
  output logic dq_pull,
  output logic bit_valid,
  output logic bit_val,
  output logic tx_done,
  output logic reset_det,
  output logic presence_done,
  output logic busy
);

  typedef enum logic [2:0] {
    IDLE,
    SLOT,
    PD_WAIT,
    PD_DRIVE,
    PD_RECOVER
  } state_t;

  localparam logic [CNT_W-1:0] MIN_LOW = CNT_W'(T_MIN_LOW);
  localparam logic [CNT_W-1:0] SAMPLE  = CNT_W'(T_SAMPLE);
  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(T_READ_HOLD - 1);
  localparam logic [CNT_W-1:0] RST_MIN = CNT_W'(T_RESET_MIN);
  localparam logic [CNT_W-1:0] RST_M1  = CNT_W'(T_RESET_MIN - 1);
  localparam logic [CNT_W-1:0] PDW_M1  = CNT_W'(T_PD_WAIT - 1);
  localparam logic [CNT_W-1:0] PDL_M1  = CNT_W'(T_PD_LOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             ten_q, ten_n;
  logic             tbit_q, tbit_n;
  logic             sample, sample_n;
  logic             dq_pull_n;
  logic             bit_valid_n, bit_val_n;
  logic             tx_done_n, reset_det_n;
  logic             presence_done_n, busy_n;

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state         <= IDLE;
      cnt           <= '0;
      ten_q         <= 1'b0;
      tbit_q        <= 1'b0;
      sample        <= 1'b0;
      dq_pull       <= 1'b0;
      bit_valid     <= 1'b0;
      bit_val       <= 1'b0;
      tx_done       <= 1'b0;
      reset_det     <= 1'b0;
      presence_done <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      ten_q         <= ten_n;
      tbit_q        <= tbit_n;
      sample        <= sample_n;
      dq_pull       <= dq_pull_n;
      bit_valid     <= bit_valid_n;
      bit_val       <= bit_val_n;
      tx_done       <= tx_done_n;
      reset_det     <= reset_det_n;
      presence_done <= presence_done_n;
      busy          <= busy_n;
    end
  end

  always_comb begin
    state_n         = state;
    cnt_n           = cnt_inc;
    ten_n           = ten_q;
    tbit_n          = tbit_q;
    sample_n        = sample;
    dq_pull_n       = dq_pull;
    bit_valid_n     = 1'b0;
    bit_val_n       = bit_val;
    tx_done_n       = 1'b0;
    reset_det_n     = 1'b0;
    presence_done_n = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = cnt;
        if (fall) begin
          state_n   = SLOT;
          cnt_n     = '0;
          ten_n     = tx_en;
          tbit_n    = tx_bit;
          dq_pull_n = tx_en && !tx_bit;
        end
      end
      SLOT: begin
        if (ten_q && !tbit_q && cnt == HOLD_M1)
          dq_pull_n = 1'b0;
        if (!ten_q && cnt == SAMPLE)
          sample_n = dq_in;
        // slot ends only once our own drive is off and the bus is high
        if (dq_in && !dq_pull) begin
          state_n   = IDLE;
          dq_pull_n = 1'b0;
          if (cnt < MIN_LOW) begin
            state_n = IDLE;
          end else if (cnt >= RST_MIN) begin
            reset_det_n = 1'b1;
            state_n     = PD_WAIT;
            cnt_n       = '0;
          end else if (ten_q) begin
            tx_done_n = 1'b1;
          end else begin
            bit_valid_n = 1'b1;
            bit_val_n   = (cnt > SAMPLE) ? sample : 1'b1;
          end
        end
      end
      PD_WAIT: begin
        if (cnt == PDW_M1) begin
          dq_pull_n = 1'b1;
          state_n   = PD_DRIVE;
          cnt_n     = '0;
        end
      end
      PD_DRIVE: begin
        if (cnt == PDL_M1) begin
          dq_pull_n = 1'b0;
          state_n   = PD_RECOVER;
          cnt_n     = '0;
        end
      end
      PD_RECOVER: begin
        if (dq_in) begin
          presence_done_n = 1'b1;
          state_n         = IDLE;
        end else if (cnt == RST_M1) begin
          // master is holding a fresh reset: resume timing it as a slot
          state_n = SLOT;
          cnt_n   = RST_MIN;
          ten_n   = 1'b0;
          tbit_n  = 1'b0;
        end
      end
      default: begin
        state_n   = IDLE;
        dq_pull_n = 1'b0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_onewire_slot_decoder.sv
// Directed bench for onewire_slot_decoder.
// Bus is modelled as wired-AND of master drive and the slave pull.
module tb_onewire_slot_decoder;

  logic clk = 1'b0;
  logic nRst;
  logic fall, tx_en, tx_bit, mlow;
  logic dq_in;
  logic dq_pull, bit_valid, bit_val;
  logic tx_done, reset_det, presence_done, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int n_bv = 0, n_txd = 0, n_rd = 0, n_pd = 0, n_pull = 0;
  int bv_val = 0, bv_cyc = 0, txd_cyc = 0, rd_cyc = 0, pd_cyc = 0;
  int pull_rise = 0;
  logic pull_q = 1'b0;

  int b_bv, b_txd, b_rd, b_pd, b_pull;
  int f;

  assign dq_in = !(mlow || dq_pull);

  always #5 clk = ~clk;

  onewire_slot_decoder dut (
    .clk(clk),
    .nRst(nRst),
    .fall(fall),
    .dq_in(dq_in),
    .tx_en(tx_en),
    .tx_bit(tx_bit),
    .dq_pull(dq_pull),
    .bit_valid(bit_valid),
    .bit_val(bit_val),
    .tx_done(tx_done),
    .reset_det(reset_det),
    .presence_done(presence_done),
    .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bit_valid) begin
      n_bv++;
      bv_val = int'(bit_val);
      bv_cyc = cyc;
    end
    if (tx_done) begin
      n_txd++;
      txd_cyc = cyc;
    end
    if (reset_det) begin
      n_rd++;
      rd_cyc = cyc;
    end
    if (presence_done) begin
      n_pd++;
      pd_cyc = cyc;
    end
    if (dq_pull) n_pull++;
    if (dq_pull && !pull_q) pull_rise = cyc;
    pull_q = dq_pull;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    b_bv   = n_bv;
    b_txd  = n_txd;
    b_rd   = n_rd;
    b_pd   = n_pd;
    b_pull = n_pull;
  endtask

  task automatic run_slot(input int low, input logic ten,
                          input logic tbit, output int fc);
    fall   = 1'b1;
    mlow   = 1'b1;
    tx_en  = ten;
    tx_bit = tbit;
    step();
    fc     = cyc;
    fall   = 1'b0;
    tx_en  = 1'b0;
    tx_bit = 1'b0;
    repeat (low - 1) step();
    mlow = 1'b0;
  endtask

  task automatic write_slot(input string tag, input int low,
                            input int exp_val);
    snap();
    run_slot(low, 1'b0, 1'b0, f);
    repeat (20) step();
    check({tag, "_bv_cnt"}, n_bv - b_bv, 1);
    check({tag, "_bv_cyc"}, bv_cyc, f + low);
    check({tag, "_bit_val"}, bv_val, exp_val);
    check({tag, "_no_txd"}, n_txd - b_txd, 0);
    check({tag, "_no_pull"}, n_pull - b_pull, 0);
    check({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    nRst   = 1'b0;
    fall   = 1'b0;
    tx_en  = 1'b0;
    tx_bit = 1'b0;
    mlow   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pull", int'(dq_pull), 0);
    check("rst_bv", int'(bit_valid), 0);
    check("rst_bval", int'(bit_val), 0);
    check("rst_txd", int'(tx_done), 0);
    check("rst_rd", int'(reset_det), 0);
    check("rst_pd", int'(presence_done), 0);
    check("rst_busy", int'(busy), 0);
    nRst = 1'b1;
    repeat (2) step();

    write_slot("w1", 60, 1);
    write_slot("w0", 700, 0);
    write_slot("at_sample", 301, 1);
    write_slot("past_sample", 302, 0);
    write_slot("min_low", 6, 1);

    snap();
    run_slot(5, 1'b0, 1'b0, f);
    repeat (10) step();
    check("short5_bv", n_bv - b_bv, 0);

    snap();
    run_slot(3, 1'b0, 1'b0, f);
    check("glitch_busy_hi", int'(busy), 1);
    step();
    check("glitch_busy_lo", int'(busy), 0);
    repeat (10) step();
    check("glitch_bv", n_bv - b_bv, 0);
    check("glitch_txd", n_txd - b_txd, 0);
    check("glitch_rd", n_rd - b_rd, 0);

    snap();
    run_slot(10, 1'b1, 1'b0, f);
    repeat (400) step();
    check("r0_pull_len", n_pull - b_pull, 300);
    check("r0_pull_rise", pull_rise, f);
    check("r0_txd_cnt", n_txd - b_txd, 1);
    check("r0_txd_cyc", txd_cyc, f + 301);
    check("r0_no_bv", n_bv - b_bv, 0);

    snap();
    run_slot(10, 1'b1, 1'b1, f);
    repeat (20) step();
    check("r1_txd_cyc", txd_cyc, f + 10);
    check("r1_txd_cnt", n_txd - b_txd, 1);
    check("r1_no_pull", n_pull - b_pull, 0);

    snap();
    run_slot(4800, 1'b0, 1'b0, f);
    repeat (1600) step();
    check("rst_det_cnt", n_rd - b_rd, 1);
    check("rst_det_cyc", rd_cyc, f + 4800);
    check("pd_rise", pull_rise, f + 5100);
    check("pd_len", n_pull - b_pull, 1200);
    check("pd_done_cnt", n_pd - b_pd, 1);
    check("pd_done_cyc", pd_cyc, f + 6301);
    check("pd_no_bv", n_bv - b_bv, 0);
    check("pd_no_txd", n_txd - b_txd, 0);
    check("pd_idle", int'(busy), 0);

    run_slot(4800, 1'b0, 1'b0, f);
    repeat (400) step();
    check("mid_pull_on", int'(dq_pull), 1);
    check("mid_busy_on", int'(busy), 1);
    nRst = 1'b0;
    #1;
    check("mid_pull_off", int'(dq_pull), 0);
    check("mid_busy_off", int'(busy), 0);
    #10;
    nRst = 1'b1;
    step();
    write_slot("post_rst", 60, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
